// File: rtl/ts_pkg.sv
// Shared types and helpers for the trajectory scheduler.
//   state_t   : scheduler phase encoding (INIT, RUN, ALIGN)
//   PRIO_*    : round-robin priority encodings for the dual-stall tie-break
//   cw_for()  : minimum stall-counter width able to hold max_stall
package ts_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        ALIGN = 2'd2
    } state_t;

    localparam logic PRIO_SRC = 1'b0;
    localparam logic PRIO_TAR = 1'b1;

    // Smallest width w with 2^w > max_stall.
    function automatic int unsigned cw_for(input int unsigned max_stall);
        return $clog2(max_stall + 1);
    endfunction

endpackage

// File: rtl/trajectory_scheduler_stall_counter.sv
// Saturating stutter counter for one codeblock copy.
//   clk, rst_n : clock, async active-low reset
//   clr        : return count to zero (takes precedence over inc)
//   inc        : count one more stutter cycle, saturating at MAX_STALL
//   at_max     : registered flag, count currently equals MAX_STALL
module stall_counter #(
    parameter int unsigned MAX_STALL = 3,
    parameter int unsigned CW        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next count: clear wins, increment stops at the bound (no wrap).
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && !at_max) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // at_max is registered from the next count so it is valid with cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            at_max <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            at_max <= (cnt_nxt == CW'(MAX_STALL));
        end
    end

endmodule

// File: rtl/trajectory_scheduler.sv
// Per-cycle source/target advance scheduler with bounded stutter and an
// on-demand alignment phase at observation points.
//   clk, rst_n                   : clock, async active-low reset
//   req_stall_src/req_stall_tar  : environment stutter requests (RUN only)
//   align                        : enter alignment phase (sampled in RUN)
//   obs_src/obs_tar              : copy is at an observation point
//   step_src/step_tar            : combinational advance qualifiers
//   started                      : registered, high once INIT has passed
//   aligned/align_fail           : registered one-cycle alignment outcome
module trajectory_scheduler
    import ts_pkg::*;
#(
    parameter int unsigned MAX_STALL = 3,
    parameter int unsigned CW        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_stall_src,
    input  logic req_stall_tar,
    input  logic align,
    input  logic obs_src,
    input  logic obs_tar,
    output logic step_src,
    output logic step_tar,
    output logic started,
    output logic aligned,
    output logic align_fail
);

    // Widen the counter if CW is too small to reach MAX_STALL.
    localparam int unsigned CNT_W = (CW > cw_for(MAX_STALL)) ? CW : cw_for(MAX_STALL);

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   prio_nxt;
    logic   aligned_nxt;
    logic   align_fail_nxt;
    logic   align_done;
    logic   wait_src;
    logic   wait_tar;
    logic   max_src;
    logic   max_tar;
    logic   active;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            prio       <= PRIO_SRC;
            started    <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            started    <= 1'b1;
            aligned    <= aligned_nxt;
            align_fail <= align_fail_nxt;
        end
    end

    // Next state and Mealy step decisions.
    always_comb begin
        state_nxt      = state;
        prio_nxt       = prio;
        step_src       = 1'b0;
        step_tar       = 1'b0;
        aligned_nxt    = 1'b0;
        align_fail_nxt = 1'b0;
        align_done     = 1'b0;
        wait_src       = 1'b0;
        wait_tar       = 1'b0;
        unique case (state)
            INIT: begin
                state_nxt = RUN;
            end
            RUN: begin
                step_src = !req_stall_src || max_src;
                step_tar = !req_stall_tar || max_tar;
                // Nobody would move: round-robin keeps progress fair.
                if (!step_src && !step_tar) begin
                    step_src = (prio == PRIO_SRC);
                    step_tar = (prio == PRIO_TAR);
                    prio_nxt = ~prio;
                end
                if (align) begin
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                // A copy already parked at an observation point waits for the other.
                wait_src = obs_src && !obs_tar;
                wait_tar = obs_tar && !obs_src;
                step_src = !wait_src || max_src;
                step_tar = !wait_tar || max_tar;
                if (obs_src && obs_tar) begin
                    aligned_nxt = 1'b1;
                    align_done  = 1'b1;
                    state_nxt   = RUN;
                end else if ((wait_src && max_src) || (wait_tar && max_tar)) begin
                    align_fail_nxt = 1'b1;
                    state_nxt      = RUN;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Counters only track stutter once the copies are running.
    assign active = (state != INIT);

    stall_counter #(
        .MAX_STALL (MAX_STALL),
        .CW        (CNT_W)
    ) u_cnt_src (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    ((active && step_src) || align_done),
        .inc    (active && !step_src),
        .at_max (max_src)
    );

    stall_counter #(
        .MAX_STALL (MAX_STALL),
        .CW        (CNT_W)
    ) u_cnt_tar (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    ((active && step_tar) || align_done),
        .inc    (active && !step_tar),
        .at_max (max_tar)
    );

endmodule

// File: tb/tb_trajectory_scheduler.sv
// Bench for trajectory_scheduler: directed vector table, reset-in-ALIGN
// sequence, then random stimulus against a cycle-level reference model.
// Observed vector order: {step_src, step_tar, started, aligned, align_fail}.
module tb_trajectory_scheduler;

    localparam int MAX = 3;

    logic clk;
    logic rst_n;
    logic req_stall_src, req_stall_tar, align, obs_src, obs_tar;
    logic step_src, step_tar, started, aligned, align_fail;

    int checks = 0;
    int errors = 0;

    trajectory_scheduler #(
        .MAX_STALL (MAX),
        .CW        (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_stall_src (req_stall_src),
        .req_stall_tar (req_stall_tar),
        .align         (align),
        .obs_src       (obs_src),
        .obs_tar       (obs_tar),
        .step_src      (step_src),
        .step_tar      (step_tar),
        .started       (started),
        .aligned       (aligned),
        .align_fail    (align_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0=init, 1=run, 2=align.
    int m_phase;
    int m_cnt_s, m_cnt_t;
    bit m_prio, m_started, m_aligned, m_fail;

    task automatic model_reset();
        m_phase = 0; m_cnt_s = 0; m_cnt_t = 0;
        m_prio = 0; m_started = 0; m_aligned = 0; m_fail = 0;
    endtask

    task automatic model_step(input logic rs, input logic rt, input logic al,
                              input logic os, input logic ot, output logic [4:0] e);
        bit s, t, fin, fail;
        int nph;
        s = 0; t = 0; fin = 0; fail = 0; nph = m_phase;
        if (m_phase == 0) begin
            nph = 1;
        end else if (m_phase == 1) begin
            s = !rs || (m_cnt_s == MAX);
            t = !rt || (m_cnt_t == MAX);
            if (!s && !t) begin
                if (m_prio) t = 1; else s = 1;
                m_prio = !m_prio;
            end
            if (al) nph = 2;
        end else begin
            s = !(os && !ot) || (m_cnt_s == MAX);
            t = !(ot && !os) || (m_cnt_t == MAX);
            fin  = os && ot;
            fail = !fin && ((os && m_cnt_s == MAX) || (ot && m_cnt_t == MAX));
            if (fin || fail) nph = 1;
        end
        e = {s, t, m_started, m_aligned, m_fail};
        if (m_phase != 0) begin
            m_cnt_s = s ? 0 : m_cnt_s + 1;
            m_cnt_t = t ? 0 : m_cnt_t + 1;
            if (fin) begin m_cnt_s = 0; m_cnt_t = 0; end
        end
        m_started = 1; m_aligned = fin; m_fail = fail; m_phase = nph;
    endtask

    task automatic check(input string name, input logic [4:0] e);
        logic [4:0] act;
        act = {step_src, step_tar, started, aligned, align_fail};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (step_src step_tar started aligned align_fail)",
                     name, act, e);
        end
    endtask

    // Drive inputs just after the edge, advance the model, sample mid-cycle.
    task automatic drive(input logic rs, input logic rt, input logic al,
                         input logic os, input logic ot, output logic [4:0] me);
        req_stall_src = rs; req_stall_tar = rt; align = al; obs_src = os; obs_tar = ot;
        model_step(rs, rt, al, os, ot, me);
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rs, rt, al, os, ot;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rs, input logic rt, input logic al,
                       input logic os, input logic ot, input logic [4:0] e, input int n);
        vec_t v;
        v.rs = rs; v.rt = rt; v.al = al; v.os = os; v.ot = ot; v.exp = e;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        logic [4:0] me;

        // Expected vectors derived by hand from the scheduling rules.
        add(0, 0, 0, 0, 0, 5'b00000, 1);  // INIT: no steps, not started
        add(0, 0, 0, 0, 0, 5'b11100, 1);  // first RUN cycle
        for (int r = 0; r < 2; r++) begin  // src stall held: 0,0,0,forced 1
            add(1, 0, 0, 0, 0, 5'b01100, 3);
            add(1, 0, 0, 0, 0, 5'b11100, 1);
        end
        for (int r = 0; r < 2; r++) begin  // both stall: round-robin src, tar
            add(1, 1, 0, 0, 0, 5'b10100, 1);
            add(1, 1, 0, 0, 0, 5'b01100, 1);
        end
        add(0, 0, 0, 0, 0, 5'b11100, 1);
        add(0, 0, 1, 0, 0, 5'b11100, 1);  // align request
        add(0, 0, 0, 1, 0, 5'b01100, 2);  // src parked, waits
        add(0, 0, 0, 1, 1, 5'b11100, 1);  // both at obs
        add(0, 0, 0, 0, 0, 5'b11110, 1);  // aligned pulse
        add(0, 0, 1, 1, 0, 5'b11100, 1);  // align again, obs ignored in RUN
        add(0, 0, 0, 1, 0, 5'b01100, 3);  // tar never arrives
        add(0, 0, 0, 1, 0, 5'b11100, 1);  // forced step aborts alignment
        add(0, 0, 0, 0, 0, 5'b11101, 1);  // align_fail pulse
        add(0, 1, 0, 0, 0, 5'b10100, 3);  // tar stall up to bound
        add(0, 1, 1, 0, 0, 5'b11100, 1);  // align with forced step
        add(1, 1, 0, 0, 0, 5'b11100, 1);  // ALIGN ignores stall requests
        add(0, 0, 0, 0, 1, 5'b10100, 1);  // tar parked waits
        add(0, 0, 0, 1, 1, 5'b11100, 1);
        add(0, 0, 0, 0, 0, 5'b11110, 1);

        rst_n = 1'b0;
        req_stall_src = 0; req_stall_tar = 0; align = 0; obs_src = 0; obs_tar = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].al, tbl[i].os, tbl[i].ot, me);
            check($sformatf("vec%0d", i), tbl[i].exp);
            next_cycle();
        end

        // Reset asserted while in ALIGN.
        drive(0, 0, 1, 0, 0, me);
        check("pre_align", me);
        next_cycle();
        drive(0, 0, 0, 1, 0, me);
        check("in_align", me);
        rst_n = 1'b0;
        #1;
        check("async_reset", 5'b00000);
        model_reset();
        next_cycle();
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, me);
        check("post_reset_init", 5'b00000);
        next_cycle();
        drive(1, 1, 0, 0, 0, me);
        check("post_reset_prio", 5'b10100);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 0, me);
            check($sformatf("post_reset_cnt%0d", k), me);
            next_cycle();
        end

        // Random stimulus against the model.
        for (int k = 0; k < 800; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), me);
            check($sformatf("rand%0d", k), me);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
